// File: rtl/uc_pkg.sv
// Shared opcode encodings, FSM state and opcode-class decode for the stack control unit.
package uc_pkg;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_MUL   = 5'h02;
    localparam logic [4:0] OP_DIV   = 5'h03;
    localparam logic [4:0] OP_AND   = 5'h04;
    localparam logic [4:0] OP_NAND  = 5'h05;
    localparam logic [4:0] OP_OR    = 5'h06;
    localparam logic [4:0] OP_XOR   = 5'h07;
    localparam logic [4:0] OP_CMP   = 5'h08;
    localparam logic [4:0] OP_NOT   = 5'h09;
    localparam logic [4:0] OP_IF_EQ = 5'h0A;
    localparam logic [4:0] OP_IF_GT = 5'h0B;
    localparam logic [4:0] OP_IF_LT = 5'h0C;
    localparam logic [4:0] OP_IF_GE = 5'h0D;
    localparam logic [4:0] OP_IF_LE = 5'h0E;
    localparam logic [4:0] OP_PUSH  = 5'h10;
    localparam logic [4:0] OP_POP   = 5'h11;
    localparam logic [4:0] OP_NOP   = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH, S_POP_B, S_POP_A, S_EXEC, S_CMP, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        CL_PUSH, CL_POP, CL_BIN, CL_UNARY, CL_CMP, CL_NOP, CL_ILL
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        if (op <= OP_CMP)                       c = CL_BIN;
        else if (op == OP_NOT)                  c = CL_UNARY;
        else if (op <= OP_IF_LE)                c = CL_CMP;
        else if (op == OP_PUSH)                 c = CL_PUSH;
        else if (op == OP_POP)                  c = CL_POP;
        else if (op == OP_NOP)                  c = CL_NOP;
        else                                    c = CL_ILL;
        return c;
    endfunction

    // Stack words an instruction consumes before it can run.
    function automatic logic [1:0] operands_needed(input op_class_t c);
        logic [1:0] n;
        case (c)
            CL_BIN, CL_CMP:   n = 2'd2;
            CL_POP, CL_UNARY: n = 2'd1;
            default:          n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uc_depth_ctr.sv
// Saturating stack-occupancy counter with overflow/underflow check of the offered instruction.
import uc_pkg::*;

module uc_depth_ctr #(
    parameter int STACK_DEPTH = 16,
    parameter int DW          = $clog2(STACK_DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  op_class_t     cls,
    output logic [DW-1:0] depth,
    output logic          viol
);

    localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

    logic [DW-1:0] depth_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          depth_q <= '0;
        else if (push && depth_q != FULL)   depth_q <= depth_q + DW'(1);
        else if (pop && depth_q != '0)      depth_q <= depth_q - DW'(1);
    end

    assign depth = depth_q;
    // Widen both sides so a 2-operand need still compares correctly for tiny stacks.
    assign viol  = ((cls == CL_PUSH) && (depth_q == FULL)) ||
                   ({2'b00, depth_q} < {{DW{1'b0}}, operands_needed(cls)});

endmodule

// File: rtl/uc_pilha_seq.sv
// Stack-datapath control unit: one instruction per valid/ready handshake, strobes decoded from state.
// Optional depth checking is compiled in with `define UC_PILHA_DEPTH_CHECK_EN.
import uc_pkg::*;

module uc_pilha_seq #(
    parameter int  STACK_DEPTH = 16,
    parameter int  DATA_WIDTH  = 16,
    localparam int DW          = $clog2(STACK_DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [4:0]            instr_op,
    input  logic [DATA_WIDTH-1:0] instr_imm,
    output logic                  done,
    output logic                  err,
    output logic                  resp_cond,
    input  logic                  cond_in,
    output logic                  wren,
    output logic                  controle_pilha,
    output logic                  en_pilha,
    output logic                  en_temp1,
    output logic                  en_temp2,
    output logic                  load_temp1,
    output logic                  load_temp2,
    output logic [4:0]            opcode,
    output logic [DATA_WIDTH-1:0] din_UC,
    output logic [DW-1:0]         depth
);

    state_t                state_q, state_d;
    logic [4:0]            op_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  err_q, cond_q;
    logic                  accept, reject, depth_viol;
    op_class_t             cls_in, cls_q;

    assign cls_in      = op_class(instr_op);
    assign cls_q       = op_class(op_q);
    assign instr_ready = (state_q == S_IDLE);
    assign accept      = instr_valid & instr_ready;
    assign reject      = (cls_in == CL_ILL) | depth_viol;

`ifdef UC_PILHA_DEPTH_CHECK_EN
    uc_depth_ctr #(.STACK_DEPTH(STACK_DEPTH), .DW(DW)) u_depth (
        .clk   (clk),
        .reset (reset),
        .push  (en_pilha & wren),
        .pop   (en_pilha & ~wren),
        .cls   (cls_in),
        .depth (depth),
        .viol  (depth_viol)
    );
`else
    assign depth      = '0;
    assign depth_viol = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            imm_q   <= '0;
            err_q   <= 1'b0;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= instr_op;
                imm_q <= instr_imm;
                err_q <= reject;
            end
            if (state_q == S_CMP) cond_q <= cond_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (reject) state_d = S_DONE;
                    else begin
                        case (cls_in)
                            CL_PUSH:          state_d = S_PUSH;
                            CL_POP, CL_UNARY: state_d = S_POP_A;
                            CL_BIN, CL_CMP:   state_d = S_POP_B;
                            default:          state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_PUSH:  state_d = S_DONE;
            S_POP_B: state_d = S_POP_A;
            S_POP_A: begin
                case (cls_q)
                    CL_BIN, CL_UNARY: state_d = S_EXEC;
                    CL_CMP:           state_d = S_CMP;
                    default:          state_d = S_DONE;
                endcase
            end
            S_EXEC, S_CMP: state_d = S_DONE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Strobes come straight from the state register so reset clears them asynchronously.
    always_comb begin
        wren           = 1'b0;
        controle_pilha = 1'b0;
        en_pilha       = 1'b0;
        en_temp1       = 1'b0;
        en_temp2       = 1'b0;
        load_temp1     = 1'b0;
        load_temp2     = 1'b0;
        done           = 1'b0;
        case (state_q)
            S_PUSH: begin
                wren     = 1'b1;
                en_pilha = 1'b1;
            end
            S_POP_B: begin
                en_pilha   = 1'b1;
                load_temp2 = 1'b1;
                en_temp2   = 1'b1;
            end
            S_POP_A: begin
                en_pilha   = 1'b1;
                load_temp1 = 1'b1;
                en_temp1   = 1'b1;
            end
            S_EXEC: begin
                wren           = 1'b1;
                controle_pilha = 1'b1;
                en_pilha       = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign err       = done & err_q;
    assign resp_cond = cond_q;
    assign opcode    = op_q;
    assign din_UC    = imm_q;

endmodule

// File: tb/tb_uc_pilha_seq.sv
// Directed scoreboard bench for uc_pilha_seq; expectations follow the depth-check macro setting.
module tb_uc_pilha_seq;

    localparam int STACK_DEPTH = 16;
    localparam int DATA_WIDTH  = 16;
    localparam int DW          = $clog2(STACK_DEPTH+1);
`ifdef UC_PILHA_DEPTH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // {wren, controle_pilha, en_pilha, en_temp1, en_temp2, load_temp1, load_temp2, done, err}
    localparam logic [8:0] T_PUSH = 9'b101000000;
    localparam logic [8:0] T_POPB = 9'b001010100;
    localparam logic [8:0] T_POPA = 9'b001101000;
    localparam logic [8:0] T_EXEC = 9'b111000000;
    localparam logic [8:0] T_CMP  = 9'b000000000;
    localparam logic [8:0] T_DONE = 9'b000000010;
    localparam logic [8:0] T_DERR = 9'b000000011;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  instr_valid, instr_ready;
    logic [4:0]            instr_op;
    logic [DATA_WIDTH-1:0] instr_imm;
    logic                  done, err, resp_cond, cond_in;
    logic                  wren, controle_pilha, en_pilha, en_temp1, en_temp2;
    logic                  load_temp1, load_temp2;
    logic [4:0]            opcode;
    logic [DATA_WIDTH-1:0] din_UC;
    logic [DW-1:0]         depth;
    logic [8:0]            stb;

    uc_pilha_seq #(.STACK_DEPTH(STACK_DEPTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_imm(instr_imm), .done(done), .err(err),
        .resp_cond(resp_cond), .cond_in(cond_in), .wren(wren), .controle_pilha(controle_pilha),
        .en_pilha(en_pilha), .en_temp1(en_temp1), .en_temp2(en_temp2),
        .load_temp1(load_temp1), .load_temp2(load_temp2), .opcode(opcode),
        .din_UC(din_UC), .depth(depth)
    );

    assign stb = {wren, controle_pilha, en_pilha, en_temp1, en_temp2,
                  load_temp1, load_temp2, done, err};

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  err;
        logic  cond;
        int    lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   mdepth = 0;
    logic mcond = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response side of the scoreboard: every done pulse must match the oldest issued instruction.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
            else begin
                e = sb.pop_front();
                chk({e.tag, "_err"},  32'(err),             32'(e.err));
                chk({e.tag, "_cond"}, 32'(resp_cond),       32'(e.cond));
                chk({e.tag, "_lat"},  32'(cyc - acc_cyc + 1), 32'(e.lat));
            end
        end
    end

    task automatic issue(input string tag, input logic [4:0] op,
                         input logic [15:0] imm, input logic c);
        logic [8:0] tr[4];
        int         n, need, delta, w;
        logic       ill, e;
        exp_t       x;
        ill = 1'b0; need = 0; delta = 0; n = 1;
        if (op <= 5'h08)                      begin need = 2; delta = -1; end
        else if (op == 5'h09)                 begin need = 1; delta = 0;  end
        else if (op <= 5'h0E)                 begin need = 2; delta = -2; end
        else if (op == 5'h10)                 delta = 1;
        else if (op == 5'h11)                 begin need = 1; delta = -1; end
        else if (op != 5'h1F)                 ill = 1'b1;
        e = ill;
        if (CHK && !ill) e = (op == 5'h10) ? (mdepth == STACK_DEPTH) : (mdepth < need);

        tr[0] = T_DONE; tr[1] = T_DONE; tr[2] = T_DONE; tr[3] = T_DONE;
        if (e)                 tr[0] = T_DERR;
        else if (op == 5'h10)  begin tr[0] = T_PUSH; n = 2; end
        else if (op == 5'h11)  begin tr[0] = T_POPA; n = 2; end
        else if (op <= 5'h08)  begin tr[0] = T_POPB; tr[1] = T_POPA; tr[2] = T_EXEC; n = 4; end
        else if (op == 5'h09)  begin tr[0] = T_POPA; tr[1] = T_EXEC; n = 3; end
        else if (op <= 5'h0E)  begin tr[0] = T_POPB; tr[1] = T_POPA; tr[2] = T_CMP;  n = 4; end

        if (!e) begin
            if (CHK) mdepth += delta;
            if (op >= 5'h0A && op <= 5'h0E) mcond = c;
        end

        w = 0;
        @(negedge clk);
        while (instr_ready !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);

        x.tag = tag; x.err = e; x.cond = mcond; x.lat = n;
        sb.push_back(x);
        instr_valid = 1'b1; instr_op = op; instr_imm = imm; cond_in = c;
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        instr_valid = 1'b0;
        instr_op    = 5'($urandom);
        instr_imm   = 16'($urandom);

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_stb%0d", tag, i), 32'(stb), 32'(tr[i]));
            chk($sformatf("%s_op%0d", tag, i), 32'(opcode), 32'(op));
            if (tr[i] == T_PUSH) chk({tag, "_din"}, 32'(din_UC), 32'(imm));
        end
        chk({tag, "_depth"}, 32'(depth), 32'(mdepth));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr_op = 5'h00; instr_imm = '0; cond_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready",  32'(instr_ready), 32'd1);
        chk("rst_opcode", 32'(opcode),      32'h1F);
        chk("rst_din",    32'(din_UC),      32'd0);
        chk("rst_depth",  32'(depth),       32'd0);
        chk("rst_stb",    32'(stb),         32'd0);
        chk("rst_cond",   32'(resp_cond),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_stb", 32'(stb), 32'd0);

        issue("push4", 5'h10, 16'h0004, 1'b0);
        issue("push2", 5'h10, 16'h0002, 1'b0);
        chk("depth_two", 32'(depth), CHK ? 32'd2 : 32'd0);
        issue("add", 5'h00, 16'h0, 1'b0);
        chk("depth_after_add", 32'(depth), CHK ? 32'd1 : 32'd0);
        issue("pop", 5'h11, 16'h0, 1'b0);

        issue("push4b", 5'h10, 16'h0004, 1'b0);
        issue("push2b", 5'h10, 16'h0002, 1'b0);
        issue("if_gt", 5'h0B, 16'h0, 1'b1);
        chk("if_gt_cond", 32'(resp_cond), 32'd1);
        issue("if_eq_empty", 5'h0A, 16'h0, 1'b0);

        issue("push7", 5'h10, 16'h0007, 1'b0);
        issue("sub_d1", 5'h01, 16'h0, 1'b0);
        issue("nop", 5'h1F, 16'h0, 1'b0);
        issue("ill15", 5'h15, 16'h0, 1'b0);
        issue("ill12", 5'h12, 16'h0, 1'b0);
        issue("ill1e", 5'h1E, 16'h0, 1'b0);
        issue("push9", 5'h10, 16'h0009, 1'b0);
        issue("not", 5'h09, 16'h0, 1'b0);
        issue("cmp", 5'h08, 16'h0, 1'b1);
        issue("if_le", 5'h0E, 16'h0, 1'b1);

        for (int i = 0; i < 18; i++) issue($sformatf("fill%0d", i), 5'h10, 16'(i * 3 + 1), 1'b0);
        chk("depth_full", 32'(depth), CHK ? 32'd16 : 32'd0);
        issue("ill15_full", 5'h15, 16'h0, 1'b0);
        issue("div",  5'h03, 16'h0, 1'b0);
        issue("nand", 5'h05, 16'h0, 1'b0);
        issue("xor",  5'h07, 16'h0, 1'b0);
        issue("if_lt", 5'h0C, 16'h0, 1'b0);
        issue("if_ge", 5'h0D, 16'h0, 1'b1);

        // Reset in the EXEC cycle of a Mul: strobes must drop without waiting for a clock.
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 5'h02; instr_imm = 16'h0;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mul_exec_stb", 32'(stb), 32'(T_EXEC));
        reset = 1'b1;
        #1;
        chk("mid_rst_stb",    32'(stb),         32'd0);
        chk("mid_rst_ready",  32'(instr_ready), 32'd1);
        chk("mid_rst_depth",  32'(depth),       32'd0);
        chk("mid_rst_opcode", 32'(opcode),      32'h1F);
        @(negedge clk);
        reset = 1'b0; mdepth = 0; mcond = 1'b0;
        issue("push_after_rst", 5'h10, 16'hBEEF, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
